seg7_spi_display: RTL and testbench
===================================

SEG7_SPI_DISPLAY -- requirements
Module: seg7_spi_display

Interface
REQ-001 Parameter DIGITS, default 2, number of 7-segment digits driven (1..4).
REQ-002 Parameter VAL_W, default 8, width of the binary input value (4..14).
REQ-003 Parameter SCLK_DIV, default 4, SCLK half-period in CLK cycles (>=1).
REQ-004 Parameter CS_MODE, default 0: 0 = one CS_N line per digit; 1 = daisy chain on CS_N[0] only.
REQ-005 Parameter BLANK_LZ, default 1: 1 = blank leading zeros.
REQ-006 Parameter SEG_ACTIVE_LOW, default 0: 1 = invert every transmitted byte.
REQ-007 CLK  in  1  single system clock, all logic on its rising edge.
REQ-008 RST_N  in  1  asynchronous, active-low reset.
REQ-009 START  in  1  request a display update, sampled only in IDLE.
REQ-010 VALUE  in  VAL_W  unsigned binary value to display, latched on accepted START.
REQ-011 DP_MASK  in  DIGITS  decimal-point enable per digit (bit 0 = units), latched with VALUE.
REQ-012 BUSY  out  1  high from the cycle after START is accepted until DONE.
REQ-013 DONE  out  1  one-cycle pulse when the last frame completes.
REQ-014 OVERFLOW  out  1  high when the latched VALUE is >= 10^DIGITS; cleared on the next accepted START.
REQ-015 SCLK  out  1  serial clock, idle low.
REQ-016 MOSI  out  1  serial data, MSB first, changes only while SCLK is low.
REQ-017 CS_N  out  DIGITS  active-low chip selects; the rising edge latches the 74HC595 outputs.

Function
REQ-018 The FSM SHALL have the states IDLE, CONV, ENC, LOAD, SHIFT, HOLD, GAP and FIN.
REQ-019 IDLE: START=1 SHALL latch VALUE and DP_MASK, clear OVERFLOW and enter CONV; START is ignored in every other state.
REQ-020 CONV SHALL perform double-dabble binary-to-BCD at one shift per cycle for exactly VAL_W cycles, then enter ENC.
REQ-021 ENC (1 cycle) SHALL map each BCD digit to a byte {dp,g,f,e,d,c,b,a}: 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F.
REQ-022 ENC SHALL OR bit 7 into a digit's byte when its DP_MASK bit is set.
REQ-023 With BLANK_LZ=1, each zero digit above the most significant nonzero digit SHALL encode as 00 (plus dp if enabled); the units digit is never blanked.
REQ-024 On overflow, every digit SHALL encode as 40 (dash), OVERFLOW SHALL be set, and DP_MASK still applies.
REQ-025 If SEG_ACTIVE_LOW=1, each byte SHALL be inverted after all the above rules are applied.
REQ-026 LOAD (1 cycle) SHALL drive the selected CS_N low, SCLK low and MOSI to the first bit.
REQ-027 SHIFT: each bit SHALL take SCLK low for SCLK_DIV cycles, then SCLK high for SCLK_DIV cycles.
REQ-028 In SHIFT, MOSI SHALL update to the next bit on the cycle SCLK falls.
REQ-029 HOLD SHALL keep CS_N low and SCLK low for SCLK_DIV cycles.
REQ-030 GAP SHALL drive all CS_N high for SCLK_DIV cycles, then go to LOAD for the next frame or to FIN.
REQ-031 In CS_MODE=0, DIGITS frames of 8 bits SHALL be sent, units digit first, frame i on CS_N[i] only.
REQ-032 In CS_MODE=1, one frame of 8*DIGITS bits SHALL be sent on CS_N[0], most significant digit first; all other CS_N are held high.
REQ-033 FIN (1 cycle) SHALL pulse DONE, drop BUSY and return to IDLE; START in FIN is ignored.
REQ-034 DONE latency from the accepted START edge SHALL be VAL_W + 2 + F*(1 + 2*SCLK_DIV*B + 2*SCLK_DIV).
REQ-035 For REQ-034: CS_MODE=0 gives F=DIGITS, B=8; CS_MODE=1 gives F=1, B=8*DIGITS.

Reset
REQ-036 RST_N=0 SHALL immediately force IDLE, BUSY=0, DONE=0, OVERFLOW=0, SCLK=0, MOSI=0, all CS_N=1 and clear all latched data.
REQ-037 Reset asserted mid-frame SHALL abort the frame with no further SCLK edges.
REQ-038 The first accepted START after RST_N rises SHALL behave exactly as from power-up.

Verification
REQ-039 DIGITS=2, CS_MODE=0, VALUE=25 -> CS_N[0] frame 6D, CS_N[1] frame 5B, DONE at the REQ-034 cycle count (156 with defaults).
REQ-040 VALUE=7 -> tens byte 00 with BLANK_LZ=1, 3F with BLANK_LZ=0; VALUE=0 -> units byte 3F.
REQ-041 DIGITS=2, VALUE=200 -> both bytes 40, OVERFLOW=1 until the next START; DP_MASK=01 -> units byte C0.
REQ-042 CS_MODE=1, VALUE=25 -> CS_N[0] low for 16 bits, MOSI stream 5B then 6D, CS_N[1] high throughout.
REQ-043 START pulsed while BUSY with VALUE changed -> ignored, transmitted bytes still reflect the original VALUE.
REQ-044 RST_N low during SHIFT -> CS_N all 1 and SCLK 0 with no clock edge; a subsequent START (VALUE=25) transmits 6D, 5B correctly.

Source files
------------

// File: rtl/seg7_spi_display.sv
// Binary value to multi-digit 7-segment display, driven over SPI into 74HC595 shift registers.
// Double-dabble conversion, segment encoding, then per-digit or daisy-chained frames.
module seg7_spi_display #(
  parameter int DIGITS         = 2,
  parameter int VAL_W          = 8,
  parameter int SCLK_DIV       = 4,
  parameter int CS_MODE        = 0,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [VAL_W-1:0]  value_i,
  input  logic [DIGITS-1:0] dp_mask_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [DIGITS-1:0] cs_n_o
);

  localparam int FB  = (CS_MODE == 1) ? 8 * DIGITS : 8;
  localparam int NF  = (CS_MODE == 1) ? 1 : DIGITS;
  localparam int DW  = $clog2(SCLK_DIV) + 1;
  localparam int BW  = $clog2(FB);
  localparam int POW = 10 ** DIGITS;

  typedef enum logic [2:0] {IDLE, CONV, ENC, LOAD, SHIFT, HOLD, GAP, FIN} state_t;

  function automatic logic [7:0] seg_lut(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic logic [4*DIGITS-1:0] dabble_adj(input logic [4*DIGITS-1:0] b);
    logic [4*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      else                     r[4*i +: 4] = b[4*i +: 4];
    end
    return r;
  endfunction

  // Walk from the most significant digit down so leading zeros can be tracked.
  function automatic logic [8*DIGITS-1:0] encode(input logic [4*DIGITS-1:0] bcd,
                                                 input logic [DIGITS-1:0]   dp,
                                                 input logic                ovf);
    logic [8*DIGITS-1:0] r;
    logic [7:0]          byt;
    logic                lead;
    lead = 1'b1;
    r    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead = lead & (bcd[4*i +: 4] == 4'd0);
      if (ovf)                                  byt = 8'h40;
      else if (BLANK_LZ == 1 && lead && i != 0) byt = 8'h00;
      else                                      byt = seg_lut(bcd[4*i +: 4]);
      if (dp[i]) byt = byt | 8'h80;
      else       byt = byt;
      if (SEG_ACTIVE_LOW == 1) byt = ~byt;
      else                     byt = byt;
      r[8*i +: 8] = byt;
    end
    return r;
  endfunction

  function automatic logic [FB-1:0] frame_word(input logic [8*DIGITS-1:0] bytes, input int f);
    logic [8*DIGITS-1:0] sh;
    sh = bytes >> (8 * f);
    return sh[FB-1:0];
  endfunction

  function automatic logic [DIGITS-1:0] cs_sel(input int f);
    if (CS_MODE == 1) return ~DIGITS'(1);
    else              return ~(DIGITS'(1) << f);
  endfunction

  state_t                    state_q, state_d;
  logic [3:0]                conv_q, conv_d;
  logic [DW-1:0]             div_q, div_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [1:0]                frame_q, frame_d;
  logic [VAL_W-1:0]          bin_q, bin_d;
  logic [4*DIGITS-1:0]       bcd_q, bcd_d;
  logic [DIGITS-1:0]         dp_q, dp_d;
  logic                      ovfp_q, ovfp_d;
  logic [8*DIGITS-1:0]       bytes_q, bytes_d;
  logic [FB-1:0]             shreg_q, shreg_d;
  logic                      sclk_q, sclk_d, mosi_q, mosi_d;
  logic [DIGITS-1:0]         cs_n_q, cs_n_d;
  logic                      busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [8*DIGITS-1:0]       enc_s;
  logic [4*DIGITS+VAL_W-1:0] dd_s;
  logic [FB-1:0]             word_s;

  assign enc_s = encode(bcd_q, dp_q, ovfp_q);
  assign dd_s  = {dabble_adj(bcd_q), bin_q} << 1;

  // Next-state and registered-output decode; outputs are set on entry to the state they belong to.
  always_comb begin
    state_d = state_q;
    conv_d  = conv_q;
    div_d   = div_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    dp_d    = dp_q;
    ovfp_d  = ovfp_q;
    bytes_d = bytes_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    word_s  = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CONV;
          bin_d   = value_i;
          dp_d    = dp_mask_i;
          bcd_d   = '0;
          conv_d  = 4'd0;
          ovfp_d  = (32'(value_i) >= 32'(POW));
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = dd_s;
        conv_d         = conv_q + 4'd1;
        if (conv_q == 4'(VAL_W - 1)) state_d = ENC;
        else                         state_d = CONV;
      end
      ENC: begin
        word_s  = frame_word(enc_s, 0);
        state_d = LOAD;
        bytes_d = enc_s;
        ovf_d   = ovfp_q;
        frame_d = 2'd0;
        shreg_d = word_s;
        mosi_d  = word_s[FB-1];
        cs_n_d  = cs_sel(0);
        sclk_d  = 1'b0;
      end
      LOAD: begin
        state_d = SHIFT;
        div_d   = '0;
        bit_d   = '0;
      end
      SHIFT: begin
        if (div_q == DW'(SCLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BW'(FB - 1)) begin
              state_d = HOLD;
            end else begin
              bit_d   = bit_q + BW'(1);
              shreg_d = shreg_q << 1;
              mosi_d  = shreg_q[FB-2];
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HOLD: begin
        if (div_q == DW'(SCLK_DIV - 1)) begin
          div_d   = '0;
          state_d = GAP;
          cs_n_d  = '1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      GAP: begin
        if (div_q == DW'(SCLK_DIV - 1)) begin
          div_d = '0;
          if (frame_q == 2'(NF - 1)) begin
            state_d = FIN;
          end else begin
            word_s  = frame_word(bytes_q, int'(frame_q) + 1);
            state_d = LOAD;
            frame_d = frame_q + 2'd1;
            shreg_d = word_s;
            mosi_d  = word_s[FB-1];
            cs_n_d  = cs_sel(int'(frame_q) + 1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = '1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      conv_q  <= 4'd0;
      div_q   <= '0;
      bit_q   <= '0;
      frame_q <= 2'd0;
      bin_q   <= '0;
      bcd_q   <= '0;
      dp_q    <= '0;
      ovfp_q  <= 1'b0;
      bytes_q <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      conv_q  <= conv_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      dp_q    <= dp_d;
      ovfp_q  <= ovfp_d;
      bytes_q <= bytes_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign sclk_o     = sclk_q;
  assign mosi_o     = mosi_q;
  assign cs_n_o     = cs_n_q;

endmodule

// File: tb/tb_seg7_spi_display.sv
// Scoreboard bench: three instances (default, no leading-zero blanking, daisy chain) share stimulus;
// per-instance monitors decode SPI frames and DONE events and compare against queued expectations.
module tb_seg7_spi_display;

  typedef struct packed {int cs; int nb; logic [31:0] d;} frm_t;
  typedef struct packed {int lat; logic ovf;} dn_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] value = 8'd0;
  logic [1:0] dp = 2'b00;

  logic [2:0] busy_w, done_w, ovf_w, sclk_w, mosi_w;
  logic [1:0] cs_w [3];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  frm_t fq [3][$];
  dn_t  dq [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg7_spi_display u_def (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .value_i(value), .dp_mask_i(dp),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .overflow_o(ovf_w[0]),
    .sclk_o(sclk_w[0]), .mosi_o(mosi_w[0]), .cs_n_o(cs_w[0]));

  seg7_spi_display #(.BLANK_LZ(0)) u_nolz (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .value_i(value), .dp_mask_i(dp),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .overflow_o(ovf_w[1]),
    .sclk_o(sclk_w[1]), .mosi_o(mosi_w[1]), .cs_n_o(cs_w[1]));

  seg7_spi_display #(.CS_MODE(1)) u_chain (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .value_i(value), .dp_mask_i(dp),
    .busy_o(busy_w[2]), .done_o(done_w[2]), .overflow_o(ovf_w[2]),
    .sclk_o(sclk_w[2]), .mosi_o(mosi_w[2]), .cs_n_o(cs_w[2]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_mon
    // SPI frame decoder and DONE/OVERFLOW checker for instance g.
    initial begin
      logic        ps;
      logic        pd;
      logic [1:0]  pc;
      logic [31:0] sh;
      int          nb;
      frm_t        e;
      dn_t         de;
      ps = 1'b0; pd = 1'b0; pc = 2'b11; sh = 32'd0; nb = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          sh = 32'd0;
          nb = 0;
        end else begin
          if (!ps && sclk_w[g]) begin
            if (cs_w[g] == 2'b11) begin
              checks++; errors++;
              $display("FAIL sclk_without_cs inst%0d at cycle %0d", g, cyc);
            end
            sh = {sh[30:0], mosi_w[g]};
            nb++;
          end
          for (int k = 0; k < 2; k++) begin
            if (!pc[k] && cs_w[g][k]) begin
              checks++;
              if (fq[g].size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected inst%0d: got cs%0d %0d bits %h, expected none", g, k, nb, sh);
              end else begin
                e = fq[g].pop_front();
                if (e.cs != k || e.nb != nb || e.d != sh) begin
                  errors++;
                  $display("FAIL frame inst%0d: got cs%0d %0d bits %h, expected cs%0d %0d bits %h",
                           g, k, nb, sh, e.cs, e.nb, e.d);
                end
              end
              sh = 32'd0;
              nb = 0;
            end
          end
          if (done_w[g] && !pd) begin
            checks++;
            if (dq[g].size() == 0) begin
              errors++;
              $display("FAIL done_unexpected inst%0d at cycle %0d", g, cyc);
            end else begin
              de = dq[g].pop_front();
              if ((cyc - start_cyc) != de.lat || ovf_w[g] != de.ovf) begin
                errors++;
                $display("FAIL done inst%0d: got latency %0d ovf %0b, expected latency %0d ovf %0b",
                         g, cyc - start_cyc, ovf_w[g], de.lat, de.ovf);
              end
            end
          end
        end
        ps = sclk_w[g];
        pc = cs_w[g];
        pd = done_w[g];
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy_w != 3'b000 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy %b, expected 000", busy_w);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic issue(input logic [7:0] v, input logic [1:0] m);
    @(negedge clk);
    value = v;
    dp    = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  // u: units byte, t: tens byte with blanking, tn: tens byte without blanking.
  task automatic xfer(input logic [7:0] v, input logic [1:0] m, input logic [7:0] u,
                      input logic [7:0] t, input logic [7:0] tn, input logic eo, input int glitch);
    fq[0].push_back('{0, 8, {24'd0, u}});
    fq[0].push_back('{1, 8, {24'd0, t}});
    fq[1].push_back('{0, 8, {24'd0, u}});
    fq[1].push_back('{1, 8, {24'd0, tn}});
    fq[2].push_back('{0, 16, {16'd0, t, u}});
    dq[0].push_back('{156, eo});
    dq[1].push_back('{156, eo});
    dq[2].push_back('{147, eo});
    issue(v, m);
    chk("busy_after_start", {29'd0, busy_w}, 32'h7);
    chk("ovf_cleared_on_start", {29'd0, ovf_w}, 32'h0);
    if (glitch >= 0) begin
      repeat (20) @(negedge clk);
      value = 8'(glitch);
      dp    = 2'b11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("reset_outputs", {27'd0, busy_w[g], done_w[g], ovf_w[g], sclk_w[g], mosi_w[g]}, 32'h0);
      chk("reset_cs", {30'd0, cs_w[g]}, 32'h3);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    xfer(8'd25,  2'b00, 8'h6D, 8'h5B, 8'h5B, 1'b0, -1);
    xfer(8'd7,   2'b00, 8'h07, 8'h00, 8'h3F, 1'b0, -1);
    xfer(8'd0,   2'b00, 8'h3F, 8'h00, 8'h3F, 1'b0, -1);
    xfer(8'd200, 2'b00, 8'h40, 8'h40, 8'h40, 1'b1, -1);
    chk("ovf_held_after_done", {29'd0, ovf_w}, 32'h7);
    xfer(8'd200, 2'b01, 8'hC0, 8'h40, 8'h40, 1'b1, -1);
    xfer(8'd93,  2'b10, 8'h4F, 8'hEF, 8'hEF, 1'b0, -1);
    xfer(8'd5,   2'b10, 8'h6D, 8'h80, 8'hBF, 1'b0, -1);
    xfer(8'd99,  2'b00, 8'h6F, 8'h6F, 8'h6F, 1'b0, -1);
    xfer(8'd100, 2'b00, 8'h40, 8'h40, 8'h40, 1'b1, -1);
    xfer(8'd25,  2'b00, 8'h6D, 8'h5B, 8'h5B, 1'b0, 88);

    // Abort mid-shift with reset, then a clean transfer.
    issue(8'd25, 2'b00);
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      fq[g].delete();
      dq[g].delete();
    end
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("abort_outputs", {27'd0, busy_w[g], done_w[g], ovf_w[g], sclk_w[g], mosi_w[g]}, 32'h0);
      chk("abort_cs", {30'd0, cs_w[g]}, 32'h3);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    xfer(8'd25, 2'b00, 8'h6D, 8'h5B, 8'h5B, 1'b0, -1);

    for (int g = 0; g < 3; g++) begin
      chk("frames_left", fq[g].size(), 32'd0);
      chk("dones_left", dq[g].size(), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
